// File: rtl/async_fifo_asym.sv
// Single-clock FIFO with asymmetric write/read widths over a byte-granular RAM.
//
// Ports:
//   clk           - clock, all logic on the rising edge
//   rst           - synchronous active-high reset (pointers and rd_data cleared)
//   wr_en         - write request, accepted when fifo_full is low
//   wr_data       - write word, MSB unit lands at the lowest RAM address
//   fifo_full     - fewer than WR_IND free RAM units
//   wr_data_count - occupancy in write-width words
//   rd_en         - read request, accepted when fifo_empty is low
//   rd_data       - registered read word, lowest RAM address in the MSBs
//   fifo_empty    - fewer than RD_IND stored RAM units
//   rd_data_count - occupancy in read-width words (floor)
module async_fifo_asym #(
  parameter int unsigned RAM_DEPTH      = 128,
  parameter int unsigned RAM_ADDR_WIDTH = 7,
  parameter int unsigned WR_WIDTH       = 16,
  parameter int unsigned RD_WIDTH       = 32,
  parameter int unsigned WR_IND         = 2,
  parameter int unsigned RD_IND         = 4,
  parameter int unsigned RAM_WIDTH      = 8,
  parameter int unsigned WR_L2          = 1,
  parameter int unsigned RD_L2          = 2,
  parameter int unsigned WR_CNT_WIDTH   = 7,
  parameter int unsigned RD_CNT_WIDTH   = 6,
  parameter int unsigned RAM_RD2WR      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WR_WIDTH-1:0]     wr_data,
  output logic                    fifo_full,
  output logic [WR_CNT_WIDTH-1:0] wr_data_count,
  input  logic                    rd_en,
  output logic [RD_WIDTH-1:0]     rd_data,
  output logic                    fifo_empty,
  output logic [RD_CNT_WIDTH-1:0] rd_data_count
);

  localparam int unsigned PtrW = RAM_ADDR_WIDTH + 1;

  // Derived parameters are passed in explicitly; reject inconsistent sets at elaboration.
  if (WR_WIDTH != WR_IND * RAM_WIDTH || RD_WIDTH != RD_IND * RAM_WIDTH ||
      RAM_DEPTH != (32'd1 << RAM_ADDR_WIDTH) || WR_IND != (32'd1 << WR_L2) ||
      RD_IND != (32'd1 << RD_L2) || WR_CNT_WIDTH != PtrW - WR_L2 ||
      RD_CNT_WIDTH != PtrW - RD_L2 ||
      RAM_RD2WR != ((RD_WIDTH > WR_WIDTH) ? RD_WIDTH / WR_WIDTH : 32'd1))
  begin : gen_param_check
    $error("async_fifo_asym: inconsistent parameter set");
  end

  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]           used;
  logic [RD_WIDTH-1:0]       rd_data_q, rd_data_d;
  logic [RAM_WIDTH-1:0]      mem_q [RAM_DEPTH];
  logic [RAM_ADDR_WIDTH-1:0] wr_addr [WR_IND];
  logic [RAM_ADDR_WIDTH-1:0] rd_addr [RD_IND];
  logic                      wr_accept, rd_accept;

  // Pointers carry one extra bit so used spans 0..RAM_DEPTH without ambiguity.
  assign used          = wr_ptr_q - rd_ptr_q;
  assign fifo_full     = used > PtrW'(RAM_DEPTH - WR_IND);
  assign fifo_empty    = used < PtrW'(RD_IND);
  assign wr_data_count = used[PtrW-1:WR_L2];
  assign rd_data_count = used[PtrW-1:RD_L2];
  assign rd_data       = rd_data_q;

  always_comb begin
    wr_accept = wr_en & ~fifo_full;
    rd_accept = rd_en & ~fifo_empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PtrW'(WR_IND);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PtrW'(RD_IND);
    for (int i = 0; i < WR_IND; i++) begin
      wr_addr[i] = wr_ptr_q[RAM_ADDR_WIDTH-1:0] + RAM_ADDR_WIDTH'(i);
    end
    for (int i = 0; i < RD_IND; i++) begin
      rd_addr[i] = rd_ptr_q[RAM_ADDR_WIDTH-1:0] + RAM_ADDR_WIDTH'(i);
    end
    // Lowest address goes to the MSBs of the read word.
    if (rd_accept) begin
      for (int i = 0; i < RD_IND; i++) begin
        rd_data_d[RD_WIDTH-1-i*RAM_WIDTH -: RAM_WIDTH] = mem_q[rd_addr[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM is never cleared; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      for (int i = 0; i < WR_IND; i++) begin
        mem_q[wr_addr[i]] <= wr_data[WR_WIDTH-1-i*RAM_WIDTH -: RAM_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_asym.sv
module tb_async_fifo_asym;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        fifo_full;
  logic [6:0]  wr_data_count;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        fifo_empty;
  logic [5:0]  rd_data_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: queue of 16-bit write words, two per 32-bit read.
  logic [15:0] model_q[$];
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  async_fifo_asym dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .fifo_full     (fifo_full),
    .wr_data_count (wr_data_count),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .fifo_empty    (fifo_empty),
    .rd_data_count (rd_data_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int unsigned units;
    units = 2 * model_q.size();
    check({tag, " rd_data"}, rd_data, exp_rd);
    check({tag, " full"}, 32'(fifo_full), 32'(units > 126));
    check({tag, " empty"}, 32'(fifo_empty), 32'(units < 4));
    check({tag, " wr_cnt"}, 32'(wr_data_count), 32'(units >> 1));
    check({tag, " rd_cnt"}, 32'(rd_data_count), 32'(units >> 2));
  endtask

  // One clock edge with optional write and read; acceptance decided from model state.
  task automatic step(input logic we, input logic [15:0] wd, input logic re, input string tag);
    logic wacc, racc;
    wacc = we && (2 * model_q.size() <= 126);
    racc = re && (2 * model_q.size() >= 4);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (racc) begin
      exp_rd = {model_q[0], model_q[1]};
      void'(model_q.pop_front());
      void'(model_q.pop_front());
    end
    if (wacc) model_q.push_back(wd);
    check_all(tag);
  endtask

  task automatic do_reset(input logic we, input string tag);
    rst     = 1'b1;
    wr_en   = we;
    wr_data = 16'hdead;
    rd_en   = 1'b0;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    model_q.delete();
    exp_rd = '0;
    check_all(tag);
  endtask

  initial begin
    // Reset
    tick();
    do_reset(1'b0, "reset");

    // First two writes: partial word not readable, then one full read word
    step(1'b1, 16'h0000, 1'b0, "wr0");
    check("wr0 empty hard", 32'(fifo_empty), 32'd1);
    step(1'b1, 16'h0001, 1'b0, "wr1");
    check("wr1 rd_cnt hard", 32'(rd_data_count), 32'd1);

    // Fill to full with incrementing data
    for (int i = 2; i < 64; i++) step(1'b1, 16'(i), 1'b0, "fill");
    check("full flag", 32'(fifo_full), 32'd1);
    check("full wr_cnt", 32'(wr_data_count), 32'd64);
    check("full rd_cnt", 32'(rd_data_count), 32'd32);
    step(1'b1, 16'hffff, 1'b0, "wr_full");

    // Drain: MSB-first order puts the earliest write word in the MSBs
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 16'h0, 1'b1, "drain");
      check("drain hard", rd_data, {16'(2 * k), 16'(2 * k + 1)});
    end
    check("drained empty", 32'(fifo_empty), 32'd1);
    step(1'b0, 16'h0, 1'b1, "rd_empty");
    check("rd_empty hold", rd_data, 32'h003e003f);

    // Half full then 20 simultaneous read/write edges
    for (int i = 0; i < 32; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, "half");
    for (int j = 0; j < 20; j++) step(1'b1, 16'(16'h0120 + j), 1'b1, "dual");
    check("dual wr_cnt hard", 32'(wr_data_count), 32'd12);
    for (int k = 0; k < 6; k++) step(1'b0, 16'h0, 1'b1, "dual_drain");
    check("dual_drain last", rd_data, 32'h01320133);

    // Reset mid-fill with wr_en high
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, "prefill");
    do_reset(1'b1, "mid_reset");

    // Repeated fill/drain so pointers and RAM addresses wrap
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 48; i++) step(1'b1, 16'((c << 12) | (i * 3)), 1'b0, "wrap_fill");
      for (int k = 0; k < 24; k++) step(1'b0, 16'h0, 1'b1, "wrap_drain");
    end
    check("wrap last", rd_data, {16'(16'h3000 | 46 * 3), 16'(16'h3000 | 47 * 3)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
